countdown_counter: RTL and testbench
====================================

// Module: countdown_counter
// PURPOSE
//  Multi-digit down-counter for the stopwatch's countdown/timer mode, the decrementing counterpart of the up-counter.
//  Holds NUMBER_OF_NYBLES digits, one nybble each, with each digit in base BASE.
//  Loads a preset value and decrements it by one on each qualified enable tick until it reaches zero.
//  Reports expiry to the display/alarm logic. Sits between the tick prescaler and the display digit mux.
// PARAMETERS
//  BASE              10  radix of every digit (2..16)
//  NUMBER_OF_NYBLES  4   number of digits; numberIn/numberOut width = 4*NUMBER_OF_NYBLES
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      asynchronous, active-low reset
//  enable     in   1      count tick (1-cycle pulse from prescaler); decrements only in RUN
//  load       in   1      1-cycle strobe: capture numberIn as new preset
//  numberIn   in   4*N    preset value, digit 0 in bits [3:0]
//  start      in   1      1-cycle strobe: begin/resume counting
//  pause      in   1      1-cycle strobe: hold count
//  numberOut  out  4*N    current count, same packing as numberIn
//  threshold  out  1      1-cycle pulse: the tick that decrements the count to all-zero
//  running    out  1      high in RUN
//  expired    out  1      level, high in DONE
// BEHAVIOUR
//  Reset (rst=0, async): numberOut=0, state=IDLE, threshold=0, running=0, expired=0.
//  States:
//   - IDLE: loaded, not counting.
//   - RUN: decrement on enable.
//   - PAUSED: hold.
//   - DONE: count==0, expired=1.
//  Priority within a cycle: load > start/pause > enable tick.
//  load (any state):
//   - capture numberIn -> state IDLE; threshold=0.
//   - Any nybble >= BASE is clamped to BASE-1 at capture.
//  start:
//   - IDLE or PAUSED -> RUN if count != 0.
//   - IDLE or PAUSED -> DONE if count == 0; expired next cycle, no threshold pulse.
//   - Ignored in RUN and DONE.
//  pause: RUN -> PAUSED. Ignored elsewhere. start and pause asserted together: pause wins.
//  enable in RUN:
//   - Digit 0 decrements. A digit at 0 wraps to BASE-1 and borrows from the next digit (ripple borrow, same cycle).
//   - If the pre-tick count == 1 (digit 0 = 1, others 0): count becomes 0, threshold pulses high for exactly that cycle, state -> DONE.
//   - The count never wraps below zero. In DONE, enable is ignored and the count stays at 0.
//  enable outside RUN: no effect.
//  Latency: numberOut, threshold, running and expired are registered and reflect a tick/strobe on the following clock edge.
//  enable on the same cycle as load: the tick is discarded, and the loaded value appears unmodified.
//  Reset mid-RUN: immediate return to reset values; the preset is lost.
// STRUCTURE
//  Shared package (stopwatch_pkg): state enum {IDLE, RUN, PAUSED, DONE}, NYBLE_W=4, digit clamp function.
//  Sub-module countdown_digit (one per digit, generate loop):
//   - Inputs: dec_in (borrow-in), load, din.
//   - Outputs: q, borrow_out (= dec_in & q==0), is_zero.
//  Top level: FSM, zero detection (AND of is_zero), threshold register.
// TESTING
//  1 Reset then load 0x0003, start, 3 ticks
//    -> numberOut 0002, 0001, 0000; threshold high on 3rd tick only; expired=1 thereafter.
//  2 Borrow chain: load 0x1000, start, 1 tick -> 0x0999; load 0x0100, tick -> 0x0099.
//  3 Pause/resume: 0x0010 running, pause, 5 ticks -> stays 0x0010; start, tick -> 0x0009.
//  4 Edge strobes:
//    - load 0x0000 then start -> DONE, expired=1, threshold never pulses.
//    - Ticks in DONE -> count stays 0000.
//  5 Simultaneity and clamp:
//    - load+enable same cycle -> numberOut == numberIn exactly.
//    - start+pause same cycle -> PAUSED.
//    - numberIn 0x00AF with BASE=10 -> 0x0099.
//  6 Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch counters: FSM state encoding,
// the digit width, and the per-digit clamp used when a preset is captured.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NYBLE_W = 4;

    // A digit that is out of range for the radix is pinned to the largest legal digit.
    function automatic logic [NYBLE_W-1:0] digit_clamp(input logic [NYBLE_W-1:0] d,
                                                       input int                 base);
        if (int'(d) >= base)
            return NYBLE_W'(base - 1);
        return d;
    endfunction

endpackage

// File: rtl/countdown_digit.sv
// One base-BASE digit of the down-counter: loads a clamped preset, decrements
// on borrow-in, and wraps 0 -> BASE-1 while passing the borrow upward.
module countdown_digit
    import stopwatch_pkg::*;
#(
    parameter int BASE = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_in,
    input  logic               load,
    input  logic [NYBLE_W-1:0] din,
    output logic [NYBLE_W-1:0] q,
    output logic               borrow_out,
    output logic               is_zero
);

    localparam logic [NYBLE_W-1:0] MAX_DIGIT = NYBLE_W'(BASE - 1);

    assign is_zero    = (q == '0);
    assign borrow_out = dec_in & is_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= digit_clamp(din, BASE);
        end else if (dec_in) begin
            q <= is_zero ? MAX_DIGIT : q - NYBLE_W'(1);
        end
    end

endmodule

// File: rtl/countdown_counter.sv
// Multi-digit countdown timer: preset load, start/pause control, ripple-borrow
// decrement on enable ticks, and a one-cycle threshold pulse on reaching zero.
module countdown_counter
    import stopwatch_pkg::*;
#(
    parameter int BASE             = 10,
    parameter int NUMBER_OF_NYBLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              load,
    input  logic [NYBLE_W*NUMBER_OF_NYBLES-1:0] numberIn,
    input  logic                              start,
    input  logic                              pause,
    output logic [NYBLE_W*NUMBER_OF_NYBLES-1:0] numberOut,
    output logic                              threshold,
    output logic                              running,
    output logic                              expired
);

    localparam int N = NUMBER_OF_NYBLES;
    localparam int W = NYBLE_W * N;

    state_t         state;
    state_t         state_nxt;
    logic [N:0]     chain;
    logic [N-1:0]   dig_zero;
    logic           all_zero;
    logic           count_is_one;
    logic           dec;

    // Load and pause both pre-empt the tick; the zero guard keeps the count from wrapping.
    assign all_zero     = &dig_zero;
    assign count_is_one = (numberOut == W'(1));
    assign dec          = enable && (state == RUN) && !load && !pause && !all_zero;
    assign chain[0]     = dec;

    for (genvar i = 0; i < N; i++) begin : g_digit
        countdown_digit #(
            .BASE(BASE)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .dec_in     (chain[i]),
            .load       (load),
            .din        (numberIn[i*NYBLE_W +: NYBLE_W]),
            .q          (numberOut[i*NYBLE_W +: NYBLE_W]),
            .borrow_out (chain[i+1]),
            .is_zero    (dig_zero[i])
        );
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (start && !pause)
                        state_nxt = all_zero ? DONE : RUN;
                end
                RUN: begin
                    if (pause)
                        state_nxt = PAUSED;
                    else if (dec && count_is_one)
                        state_nxt = DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            threshold <= 1'b0;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_nxt;
            threshold <= dec && count_is_one && !chain[N];
            running   <= (state_nxt == RUN);
            expired   <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_countdown_counter.sv
// Directed bench for countdown_counter: a driver pushes the expected outputs of
// each stimulus cycle into a queue that a monitor pops and checks after the edge.
module tb_countdown_counter;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] num;
        logic         thr;
        logic         run;
        logic         exp;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] numberIn = '0;
    logic [W-1:0] numberOut;
    logic         threshold;
    logic         running;
    logic         expired;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    countdown_counter #(
        .BASE             (10),
        .NUMBER_OF_NYBLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .numberIn  (numberIn),
        .start     (start),
        .pause     (pause),
        .numberOut (numberOut),
        .threshold (threshold),
        .running   (running),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        total++;
        if (numberOut !== e.num || threshold !== e.thr || running !== e.run || expired !== e.exp) begin
            bad++;
            $display("FAIL %s: got num=%h thr=%b run=%b exp=%b, want num=%h thr=%b run=%b exp=%b",
                     e.name, numberOut, threshold, running, expired, e.num, e.thr, e.run, e.exp);
        end
    endtask

    // Monitor: outputs settle on the rising edge, so check shortly after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0)
            check(exp_q.pop_front());
    end

    task automatic step(input logic ld, input logic st, input logic ps, input logic en,
                        input logic [W-1:0] din, input logic [W-1:0] e_num,
                        input logic e_thr, input logic e_run, input logic e_exp,
                        input string nm);
        exp_t e;
        @(negedge clk);
        load     = ld;
        start    = st;
        pause    = ps;
        enable   = en;
        numberIn = din;
        e.num  = e_num;
        e.thr  = e_thr;
        e.run  = e_run;
        e.exp  = e_exp;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        e.num = '0; e.thr = 0; e.run = 0; e.exp = 0; e.name = "reset_state";
        check(e);
        @(negedge clk);
        rst = 1'b1;

        // Basic countdown to expiry, then ticks in DONE
        step(1,0,0,0, 16'h0003, 16'h0003, 0,0,0, "t1_load");
        step(0,1,0,0, 16'h0000, 16'h0003, 0,1,0, "t1_start");
        step(0,0,0,1, 16'h0000, 16'h0002, 0,1,0, "t1_tick1");
        step(0,0,0,1, 16'h0000, 16'h0001, 0,1,0, "t1_tick2");
        step(0,0,0,1, 16'h0000, 16'h0000, 1,0,1, "t1_tick3");
        step(0,0,0,0, 16'h0000, 16'h0000, 0,0,1, "t1_after");
        step(0,0,0,1, 16'h0000, 16'h0000, 0,0,1, "t4_done_tick1");
        step(0,0,0,1, 16'h0000, 16'h0000, 0,0,1, "t4_done_tick2");

        // Borrow chains
        step(1,0,0,0, 16'h1000, 16'h1000, 0,0,0, "t2_load1000");
        step(0,1,0,0, 16'h0000, 16'h1000, 0,1,0, "t2_start1");
        step(0,0,0,1, 16'h0000, 16'h0999, 0,1,0, "t2_borrow3");
        step(1,0,0,0, 16'h0100, 16'h0100, 0,0,0, "t2_load0100");
        step(0,1,0,0, 16'h0000, 16'h0100, 0,1,0, "t2_start2");
        step(0,0,0,1, 16'h0000, 16'h0099, 0,1,0, "t2_borrow2");

        // Pause / resume, and start+pause together
        step(1,0,0,0, 16'h0010, 16'h0010, 0,0,0, "t3_load");
        step(0,1,0,0, 16'h0000, 16'h0010, 0,1,0, "t3_start");
        step(0,0,1,0, 16'h0000, 16'h0010, 0,0,0, "t3_pause");
        for (int i = 0; i < 5; i++)
            step(0,0,0,1, 16'h0000, 16'h0010, 0,0,0, "t3_paused_tick");
        step(0,1,0,0, 16'h0000, 16'h0010, 0,1,0, "t3_resume");
        step(0,0,0,1, 16'h0000, 16'h0009, 0,1,0, "t3_tick");
        step(0,1,1,1, 16'h0000, 16'h0009, 0,0,0, "t5_start_pause");
        step(0,1,0,0, 16'h0000, 16'h0009, 0,1,0, "t5_resume");

        // Zero preset goes straight to DONE without a threshold pulse
        step(1,0,0,0, 16'h0000, 16'h0000, 0,0,0, "t4_load0");
        step(0,1,0,0, 16'h0000, 16'h0000, 0,0,1, "t4_start0");
        step(0,0,0,0, 16'h0000, 16'h0000, 0,0,1, "t4_hold0");

        // Load beats a simultaneous tick; clamping of out-of-range digits
        step(1,0,0,0, 16'h0005, 16'h0005, 0,0,0, "t5_load5");
        step(0,1,0,0, 16'h0000, 16'h0005, 0,1,0, "t5_start5");
        step(1,0,0,1, 16'h1234, 16'h1234, 0,0,0, "t5_load_tick");
        step(1,0,0,0, 16'h00AF, 16'h0099, 0,0,0, "t5_clamp00AF");
        step(1,0,0,0, 16'hFFFF, 16'h9999, 0,0,0, "t5_clampFFFF");
        step(0,1,0,0, 16'h0000, 16'h9999, 0,1,0, "t5_start9999");
        step(0,0,0,1, 16'h0000, 16'h9998, 0,1,0, "t5_tick9999");

        // Async reset in the middle of a run
        step(1,0,0,0, 16'h0500, 16'h0500, 0,0,0, "t6_load");
        step(0,1,0,0, 16'h0000, 16'h0500, 0,1,0, "t6_start");
        step(0,0,0,1, 16'h0000, 16'h0499, 0,1,0, "t6_tick");
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        e.num = '0; e.thr = 0; e.run = 0; e.exp = 0; e.name = "t6_async_reset";
        check(e);
        @(negedge clk);
        rst = 1'b1;
        step(0,0,0,0, 16'h0000, 16'h0000, 0,0,0, "t6_idle_after");
        step(0,1,0,0, 16'h0000, 16'h0000, 0,0,1, "t6_preset_lost");

        @(negedge clk);
        load = 0; start = 0; pause = 0; enable = 0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
